mod_symbol_sched: RTL and testbench

//  Sequencer between the bit FIFO (SynFifo) and the modulator sample datapath.

---
 rtl/mod_symbol_sched_if.sv | 35 +++
 rtl/mod_symbol_sched.sv | 114 +++++++++++
 tb/tb_mod_symbol_sched.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mod_symbol_sched_if.sv
// Handshake and status bundle between the bit FIFO, the symbol scheduler and the sample datapath.
// master drives the FIFO/control side, slave is the scheduler.
interface mod_symbol_sched_if #(
    parameter int unsigned IDX_W = 4,
    parameter int unsigned CNT_W = 8
);
    logic             enable;
    logic [1:0]       mod_sel;
    logic             clr_err;
    logic             bEmpty;
    logic             send_in;
    logic [15:0]      data_pt;
    logic             rEN;
    logic             sym_bit;
    logic [1:0]       sym_mod;
    logic             sample_en;
    logic [IDX_W-1:0] sample_idx;
    logic             sym_start;
    logic             busy;
    logic [CNT_W-1:0] sym_count;
    logic             underrun;
    logic             timeout_err;

    modport master (
        output enable, mod_sel, clr_err, bEmpty, send_in, data_pt,
        input  rEN, sym_bit, sym_mod, sample_en, sample_idx, sym_start, busy, sym_count,
               underrun, timeout_err
    );

    modport slave (
        input  enable, mod_sel, clr_err, bEmpty, send_in, data_pt,
        output rEN, sym_bit, sym_mod, sample_en, sample_idx, sym_start, busy, sym_count,
               underrun, timeout_err
    );
endinterface

// File: rtl/mod_symbol_sched.sv
// Symbol scheduler: fetches one bit per symbol from the FIFO, then emits a fixed run of
// sample enables for the modulator, flagging stream gaps and unanswered FIFO requests.
module mod_symbol_sched #(
    parameter int unsigned SAMPLES_PER_SYM = 16,
    parameter int unsigned IDX_W           = 4,
    parameter int unsigned CNT_W           = 8,
    parameter int unsigned TIMEOUT         = 15
) (
    input logic             CLK,
    input logic             RESET,
    mod_symbol_sched_if.slave bus
);
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StReq, StEmit} state_t;

    state_t           stateQ, stateD;
    logic [IDX_W-1:0] idxQ, idxD;
    logic [WAIT_W-1:0] waitQ, waitD;
    logic             rEnQ, rEnD;
    logic             symBitQ, symBitD;
    logic [1:0]       symModQ, symModD;
    logic [CNT_W-1:0] symCountQ, symCountD;
    logic             underrunQ, underrunD;
    logic             timeoutQ, timeoutD;
    logic             underrunSet, timeoutSet;
    logic             lastSample;
    logic             unusedData;

    assign lastSample = (idxQ == IDX_W'(SAMPLES_PER_SYM - 1));
    assign unusedData = ^bus.data_pt[15:1];

    always_comb begin
        stateD      = stateQ;
        idxD        = idxQ;
        waitD       = waitQ;
        symBitD     = symBitQ;
        symModD     = symModQ;
        symCountD   = symCountQ;
        underrunSet = 1'b0;
        timeoutSet  = 1'b0;
        unique case (stateQ)
            StIdle: begin
                waitD = '0;
                if (bus.enable && !bus.bEmpty) stateD = StReq;
            end
            StReq: begin
                if (bus.send_in) begin
                    stateD    = StEmit;
                    symBitD   = bus.data_pt[0];
                    symModD   = (bus.mod_sel == 2'b11) ? 2'b00 : bus.mod_sel;
                    symCountD = symCountQ + CNT_W'(1);
                    idxD      = '0;
                    waitD     = '0;
                end else if (waitQ == WAIT_W'(TIMEOUT - 1)) begin
                    stateD     = StIdle;
                    timeoutSet = 1'b1;
                    waitD      = '0;
                end else begin
                    waitD = waitQ + WAIT_W'(1);
                end
            end
            StEmit: begin
                if (lastSample) begin
                    idxD        = '0;
                    stateD      = (bus.enable && !bus.bEmpty) ? StReq : StIdle;
                    underrunSet = bus.enable && bus.bEmpty;
                end else begin
                    idxD = idxQ + IDX_W'(1);
                end
            end
            default: stateD = StIdle;
        endcase
        // Request rises one cycle after REQ entry and drops on the edge that leaves REQ.
        rEnD      = (stateQ == StReq) && (stateD == StReq);
        underrunD = underrunSet ? 1'b1 : (bus.clr_err ? 1'b0 : underrunQ);
        timeoutD  = timeoutSet ? 1'b1 : (bus.clr_err ? 1'b0 : timeoutQ);
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            stateQ    <= StIdle;
            idxQ      <= '0;
            waitQ     <= '0;
            rEnQ      <= 1'b0;
            symBitQ   <= 1'b0;
            symModQ   <= 2'b00;
            symCountQ <= '0;
            underrunQ <= 1'b0;
            timeoutQ  <= 1'b0;
        end else begin
            stateQ    <= stateD;
            idxQ      <= idxD;
            waitQ     <= waitD;
            rEnQ      <= rEnD;
            symBitQ   <= symBitD;
            symModQ   <= symModD;
            symCountQ <= symCountD;
            underrunQ <= underrunD;
            timeoutQ  <= timeoutD;
        end
    end

    assign bus.rEN         = rEnQ;
    assign bus.sym_bit     = symBitQ;
    assign bus.sym_mod     = symModQ;
    assign bus.sample_en   = (stateQ == StEmit);
    assign bus.sample_idx  = idxQ;
    assign bus.sym_start   = (stateQ == StEmit) && (idxQ == '0);
    assign bus.busy        = (stateQ != StIdle);
    assign bus.sym_count   = symCountQ;
    assign bus.underrun    = underrunQ;
    assign bus.timeout_err = timeoutQ;
endmodule

// File: tb/tb_mod_symbol_sched.sv
// Scoreboard bench for mod_symbol_sched: a FIFO responder pushes expected samples when it
// answers rEN, and a monitor pops and compares them as sample_en cycles appear.
module tb_mod_symbol_sched;
    localparam int unsigned N       = 16;
    localparam int unsigned TIMEOUT = 15;

    typedef struct {
        logic       b;
        logic [1:0] m;
        logic [3:0] idx;
        int         c;
    } exp_t;

    logic CLK;
    logic RESET;
    mod_symbol_sched_if #(.IDX_W(4), .CNT_W(8)) bus ();

    mod_symbol_sched #(
        .SAMPLES_PER_SYM(N),
        .IDX_W          (4),
        .CNT_W          (8),
        .TIMEOUT        (TIMEOUT)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus)
    );

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   sampleCount = 0;
    int   startCount = 0;
    int   respDelay = 0;
    bit   respEnable = 0;
    bit   forceNonEmpty = 0;
    logic fifo[$];
    exp_t expQ[$];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    // FIFO responder: answers rEN after respDelay cycles and records the expected symbol.
    initial begin
        int   waitCnt;
        logic b;
        waitCnt     = 0;
        bus.send_in = 1'b0;
        bus.data_pt = 16'h0;
        bus.bEmpty  = 1'b1;
        forever begin
            @(negedge CLK);
            if (bus.send_in) begin
                bus.send_in = 1'b0;
            end else if (respEnable && bus.rEN === 1'b1 && fifo.size() > 0) begin
                if (waitCnt >= respDelay) begin
                    b           = fifo.pop_front();
                    bus.data_pt = {15'($urandom), b};
                    bus.send_in = 1'b1;
                    waitCnt     = 0;
                    for (int i = 0; i < N; i++) begin
                        exp_t e;
                        e.b   = b;
                        e.m   = (bus.mod_sel == 2'b11) ? 2'b00 : bus.mod_sel;
                        e.idx = 4'(i);
                        e.c   = cyc;
                        expQ.push_back(e);
                    end
                end else begin
                    waitCnt++;
                end
            end else begin
                waitCnt = 0;
            end
            bus.bEmpty = (fifo.size() == 0) && !forceNonEmpty;
        end
    end

    // Monitor: every sample cycle is checked against the scoreboard head.
    initial forever begin
        exp_t e;
        @(negedge CLK);
        if (bus.sample_en === 1'b1) begin
            sampleCount++;
            startCount += int'(bus.sym_start);
            tests++;
            if (expQ.size() == 0) begin
                fails++;
                $display("FAIL unexpected_sample: idx=%0d with empty scoreboard", bus.sample_idx);
            end else begin
                e = expQ.pop_front();
                if ({bus.sym_bit, bus.sym_mod, bus.sample_idx, bus.sym_start} !==
                    {e.b, e.m, e.idx, e.idx == 4'd0}) begin
                    fails++;
                    $display("FAIL sample: got bit=%b mod=%b idx=%0d start=%b, want bit=%b mod=%b idx=%0d start=%b",
                             bus.sym_bit, bus.sym_mod, bus.sample_idx, bus.sym_start,
                             e.b, e.m, e.idx, e.idx == 4'd0);
                end
                if (e.idx == 4'd0) begin
                    tests++;
                    if (cyc !== e.c + 1) begin
                        fails++;
                        $display("FAIL latency: first sample at cycle %0d, want %0d", cyc, e.c + 1);
                    end
                end
            end
        end else if (bus.sym_start !== 1'b0) begin
            tests++;
            fails++;
            $display("FAIL sym_start_outside_emit: got %b, want 0", bus.sym_start);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge CLK);
            #1;
        end
    endtask

    function automatic logic [20:0] outs();
        return {bus.rEN, bus.sym_bit, bus.sym_mod, bus.sample_en, bus.sample_idx, bus.sym_start,
                bus.busy, bus.sym_count, bus.underrun, bus.timeout_err};
    endfunction

    task automatic apply_reset();
        RESET         = 1'b0;
        bus.enable    = 1'b0;
        bus.clr_err   = 1'b0;
        bus.mod_sel   = 2'b00;
        respEnable    = 0;
        forceNonEmpty = 0;
        fifo.delete();
        step(2);
        RESET = 1'b1;
        expQ.delete();
        sampleCount = 0;
        startCount  = 0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            step(1);
            if (bus.busy === 1'b0 && bus.sample_en === 1'b0) begin
                ok = 1;
                break;
            end
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s_idle_timeout: busy=%b after %0d cycles, want 0", name, bus.busy, budget);
        end
    endtask

    task automatic test_reset();
        RESET         = 1'b0;
        bus.enable    = 1'b1;
        bus.clr_err   = 1'b0;
        bus.mod_sel   = 2'b10;
        forceNonEmpty = 1;
        step(1);
        for (int i = 0; i < 2; i++) begin
            step(1);
            tests++;
            if (outs() !== 21'h0) begin
                fails++;
                $display("FAIL reset_outputs: got %h, want 0", outs());
            end
        end
        bus.enable    = 1'b0;
        forceNonEmpty = 0;
        RESET         = 1'b1;
        step(2);
        tests++;
        if (bus.rEN !== 1'b0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: rEN=%b busy=%b, want 0 0", bus.rEN, bus.busy);
        end
    endtask

    task automatic test_single_symbol();
        bit ok;
        apply_reset();
        bus.mod_sel = 2'b10;
        fifo.push_back(1'b1);
        respDelay  = 3;
        respEnable = 1;
        bus.enable = 1'b1;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (bus.rEN === 1'b1) begin
                ok = 1;
                break;
            end
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL single_rEN: rEN=%b, want 1 within 20 cycles", bus.rEN);
        end
        bus.enable = 1'b0;
        for (int i = 0; i < 20 && sampleCount == 0; i++) step(1);
        bus.mod_sel = 2'b01;  // must not affect the symbol in flight
        wait_idle(40, "single");
        tests++;
        if (sampleCount !== N || startCount !== 1) begin
            fails++;
            $display("FAIL single_counts: samples=%0d starts=%0d, want %0d 1", sampleCount, startCount, N);
        end
        tests++;
        if ({bus.sym_bit, bus.sym_mod, bus.sym_count} !== {1'b1, 2'b10, 8'd1}) begin
            fails++;
            $display("FAIL single_latched: bit=%b mod=%b count=%0d, want 1 10 1",
                     bus.sym_bit, bus.sym_mod, bus.sym_count);
        end
        tests++;
        if (bus.rEN !== 1'b0 || bus.underrun !== 1'b0 || expQ.size() != 0) begin
            fails++;
            $display("FAIL single_end: rEN=%b underrun=%b pending=%0d, want 0 0 0",
                     bus.rEN, bus.underrun, expQ.size());
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        apply_reset();
        bus.mod_sel = 2'b11;
        for (int i = 0; i < 8; i++) fifo.push_back(1'(i % 2));
        respDelay  = 0;
        respEnable = 1;
        bus.enable = 1'b1;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            step(1);
            if (sampleCount == 8 * N && bus.busy === 1'b0) begin
                ok = 1;
                break;
            end
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL stream_done: samples=%0d busy=%b, want %0d 0", sampleCount, bus.busy, 8 * N);
        end
        tests++;
        if (startCount !== 8 || bus.sym_count !== 8'd8) begin
            fails++;
            $display("FAIL stream_counts: starts=%0d sym_count=%0d, want 8 8", startCount, bus.sym_count);
        end
        tests++;
        if ({bus.underrun, bus.timeout_err, bus.sym_bit, bus.sym_mod} !== 5'b10100) begin
            fails++;
            $display("FAIL stream_flags: underrun=%b timeout=%b bit=%b mod=%b, want 1 0 1 00",
                     bus.underrun, bus.timeout_err, bus.sym_bit, bus.sym_mod);
        end
        bus.clr_err = 1'b1;
        step(1);
        bus.clr_err = 1'b0;
        bus.enable  = 1'b0;
        tests++;
        if (bus.underrun !== 1'b0) begin
            fails++;
            $display("FAIL underrun_clear: got %b, want 0", bus.underrun);
        end
    endtask

    task automatic test_timeout();
        int busyCnt;
        int renCnt;
        bit ok;
        apply_reset();
        forceNonEmpty = 1;
        bus.enable    = 1'b1;
        busyCnt = 0;
        renCnt  = 0;
        ok      = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            busyCnt += int'(bus.busy);
            renCnt  += int'(bus.rEN);
            if (bus.timeout_err === 1'b1) begin
                ok = 1;
                break;
            end
        end
        bus.enable    = 1'b0;
        forceNonEmpty = 0;
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL timeout_flag: timeout_err=%b after 40 cycles, want 1", bus.timeout_err);
        end
        tests++;
        if (busyCnt !== TIMEOUT || renCnt !== TIMEOUT - 1 || bus.rEN !== 1'b0) begin
            fails++;
            $display("FAIL timeout_window: req=%0d rEN_high=%0d rEN=%b, want %0d %0d 0",
                     busyCnt, renCnt, bus.rEN, TIMEOUT, TIMEOUT - 1);
        end
        step(1);
        bus.clr_err = 1'b1;
        step(1);
        bus.clr_err = 1'b0;
        tests++;
        if (bus.timeout_err !== 1'b0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL timeout_clear: timeout_err=%b busy=%b, want 0 0", bus.timeout_err, bus.busy);
        end
    endtask

    task automatic test_enable_drop();
        int renAfter;
        bit ok;
        apply_reset();
        bus.mod_sel = 2'b01;
        fifo.push_back(1'b1);
        fifo.push_back(1'b0);
        respDelay  = 1;
        respEnable = 1;
        bus.enable = 1'b1;
        ok = 0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (bus.sample_en === 1'b1 && bus.sample_idx === 4'd5) begin
                ok = 1;
                break;
            end
        end
        bus.enable = 1'b0;
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL drop_reach_sample5: sample_idx=%0d, want 5 within 30 cycles", bus.sample_idx);
        end
        renAfter = 0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            renAfter += int'(bus.rEN);
        end
        tests++;
        if (sampleCount !== N || renAfter !== 0 || fifo.size() != 1) begin
            fails++;
            $display("FAIL drop_finish: samples=%0d rEN_high=%0d fifo_left=%0d, want %0d 0 1",
                     sampleCount, renAfter, fifo.size(), N);
        end
        tests++;
        if (bus.underrun !== 1'b0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL drop_flags: underrun=%b busy=%b, want 0 0", bus.underrun, bus.busy);
        end
    endtask

    task automatic test_mid_reset();
        bit ok;
        apply_reset();
        bus.mod_sel = 2'b10;
        fifo.push_back(1'b1);
        fifo.push_back(1'b1);
        respDelay  = 0;
        respEnable = 1;
        bus.enable = 1'b1;
        ok = 0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (bus.sample_en === 1'b1 && bus.sample_idx === 4'd7) begin
                ok = 1;
                break;
            end
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL midreset_reach_sample7: sample_idx=%0d, want 7", bus.sample_idx);
        end
        RESET      = 1'b0;
        respEnable = 0;
        step(1);
        expQ.delete();
        tests++;
        if (outs() !== 21'h0) begin
            fails++;
            $display("FAIL midreset_outputs: got %h, want 0", outs());
        end
        RESET      = 1'b1;
        bus.enable = 1'b0;
        step(3);
        tests++;
        if (bus.busy !== 1'b0 || bus.sym_count !== 8'd0) begin
            fails++;
            $display("FAIL midreset_after: busy=%b sym_count=%0d, want 0 0", bus.busy, bus.sym_count);
        end
    endtask

    initial begin
        RESET       = 1'b0;
        bus.enable  = 1'b0;
        bus.clr_err = 1'b0;
        bus.mod_sel = 2'b00;
        test_reset();
        test_single_symbol();
        test_back_to_back();
        test_timeout();
        test_enable_drop();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1);
    end
endmodule
